// File: rtl/demux_32bit_stream.sv
// 1-to-2 stream demultiplexer with one output register per sink.
// A burst stays on the sink chosen by its first word until in_last is accepted.
module demux_32bit_stream #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             s,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_last,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_last,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic             busy
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   logic [0:0] state_q, state_d;
   logic       lock_sel_q, lock_sel_d;
   logic       target;
   logic       accept;
   logic [1:0] sink_ready;
   logic [1:0] slot_free;

   assign sink_ready = {out1_ready, out0_ready};
   assign target     = (state_q == ST_BURST) ? lock_sel_q : s;
   // A slot is free when empty or when its current word drains on this edge.
   assign in_ready   = slot_free[target];
   assign accept     = in_valid && in_ready;
   assign busy       = (state_q == ST_BURST);

   always_comb begin
      state_d    = state_q;
      lock_sel_d = lock_sel_q;
      if (accept) begin
         if (state_q == ST_IDLE) begin
            if (!in_last) begin
               state_d    = ST_BURST;
               lock_sel_d = s;
            end
         end else if (in_last) begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         lock_sel_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_sel_q <= lock_sel_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         logic             valid_q, valid_d;
         logic [WIDTH-1:0] data_q, data_d;
         logic             last_q, last_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             acc_here;

         assign acc_here      = accept && (target == 1'(gi));
         assign slot_free[gi] = !valid_q || sink_ready[gi];

         always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            last_d  = last_q;
            cnt_d   = cnt_q;
            if (acc_here) begin
               valid_d = 1'b1;
               data_d  = in_data;
               last_d  = in_last;
               cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (valid_q && sink_ready[gi]) begin
               valid_d = 1'b0;
            end
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               valid_q <= 1'b0;
               data_q  <= '0;
               last_q  <= 1'b0;
               cnt_q   <= '0;
            end else begin
               valid_q <= valid_d;
               data_q  <= data_d;
               last_q  <= last_d;
               cnt_q   <= cnt_d;
            end
         end
      end
   endgenerate

   assign out0_valid = g_ch[0].valid_q;
   assign out0_data  = g_ch[0].data_q;
   assign out0_last  = g_ch[0].last_q;
   assign cnt0       = g_ch[0].cnt_q;
   assign out1_valid = g_ch[1].valid_q;
   assign out1_data  = g_ch[1].data_q;
   assign out1_last  = g_ch[1].last_q;
   assign cnt1       = g_ch[1].cnt_q;

endmodule
